// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, fetch FSM
// state encodings and the next-PC operation codes used by the ID stage.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_op_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register: loads on i_load, drops to a bubble on i_bubble,
// and keeps the instruction/PC fields untouched while bubbling or stalled.
module ifid_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
            r_pc4   <= 32'd0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and
// fills IF/ID. Redirects never cancel the in-flight fetch (branch delay slot).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4
);

    fetch_state_e r_state;
    logic         r_req;
    logic [31:0]  r_pc;
    logic [31:0]  r_tgt;
    logic         r_tgt_valid;
    logic [31:0]  r_skid;

    logic         w_we;
    logic         w_accept;
    logic         w_bubble;
    logic [31:0]  w_npc;
    logic [31:0]  w_pc4;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_instr;

    assign w_we      = !stall || !ifid_valid;
    // Response data only counts in WAIT; anything seen in REQ/HOLD is stale.
    assign w_accept  = ((r_state == FS_WAIT) && imem_rvalid && w_we) ||
                       ((r_state == FS_HOLD) && w_we);
    assign w_bubble  = !stall && !w_accept;
    assign w_npc     = word_align(npc_in);
    assign w_pc4     = r_pc + 32'd4;
    assign w_pc_next = redirect    ? w_npc :
                       r_tgt_valid ? r_tgt : w_pc4;
    assign w_instr   = (r_state == FS_HOLD) ? r_skid : imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FS_REQ;
            r_req       <= 1'b1;
            r_pc        <= RESET_PC;
            r_tgt_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pc        <= w_pc_next;
                r_tgt_valid <= 1'b0;
            end else if (redirect) begin
                r_tgt_valid <= 1'b1;
            end
            case (r_state)
                FS_REQ: begin
                    r_state <= FS_WAIT;
                    r_req   <= 1'b0;
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (w_we) begin
                            r_state <= FS_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (w_we) begin
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FS_REQ;
                    r_req   <= 1'b1;
                end
            endcase
        end
    end

    // Pending target and skid word carry no reset; their flags qualify them.
    always_ff @(posedge clk) begin
        if (redirect && !w_accept) begin
            r_tgt <= w_npc;
        end
        if ((r_state == FS_WAIT) && imem_rvalid && !w_we) begin
            r_skid <= imem_rdata;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;

    ifid_reg u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_bubble (w_bubble),
        .i_instr  (w_instr),
        .i_pc     (r_pc),
        .i_pc4    (w_pc4),
        .o_valid  (ifid_valid),
        .o_instr  (ifid_instr),
        .o_pc     (ifid_pc),
        .o_pc4    (ifid_pc4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are checked on the
// falling edge, so every step covers exactly one rising edge of the DUT.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc_in;
    logic        redirect;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    int n_pass = 0;
    int n_chk  = 0;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_in      (npc_in),
        .redirect    (redirect),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic resp(input logic v, input logic [31:0] d);
        imem_rvalid = v;
        imem_rdata  = d;
    endtask

    initial begin
        rst_n = 1'b0; npc_in = 32'd0; redirect = 1'b0; stall = 1'b0;
        resp(1'b0, 32'd0);
        step(); step();
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        chk("rst_pc",    ifid_pc,    32'd0);
        chk("rst_pc4",   ifid_pc4,   32'd0);
        rst_n = 1'b1;
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h3000);

        // Sequential fetch with 1-cycle memory.
        step(); chk("wait_noreq", {31'd0, imem_req}, 32'd0);
        resp(1'b1, word_of(32'h3000));
        step(); resp(1'b0, 32'd0);
        chk("seq0_valid", {31'd0, ifid_valid}, 32'd1);
        chk("seq0_pc",    ifid_pc,    32'h3000);
        chk("seq0_pc4",   ifid_pc4,   32'h3004);
        chk("seq0_instr", ifid_instr, word_of(32'h3000));
        chk("seq1_addr",  imem_addr,  32'h3004);
        chk("seq1_req",   {31'd0, imem_req}, 32'd1);
        step();
        chk("bubble_valid", {31'd0, ifid_valid}, 32'd0);
        chk("bubble_pc",    ifid_pc, 32'h3000);
        resp(1'b1, word_of(32'h3004));
        step(); resp(1'b0, 32'd0);
        chk("seq1_pc",   ifid_pc,   32'h3004);
        chk("seq2_addr", imem_addr, 32'h3008);

        // Redirect while fetch 0x3008 is outstanding: it is the delay slot.
        step(); redirect = 1'b1; npc_in = 32'h3401;
        step(); redirect = 1'b0; resp(1'b1, word_of(32'h3008));
        step(); resp(1'b0, 32'd0);
        chk("dslot_pc",    ifid_pc,   32'h3008);
        chk("dslot_valid", {31'd0, ifid_valid}, 32'd1);
        chk("redir_addr",  imem_addr, 32'h3400);

        // Stall with a valid IF/ID: response goes to the skid register.
        stall = 1'b1;
        step();
        chk("stall_hold_valid", {31'd0, ifid_valid}, 32'd1);
        resp(1'b1, word_of(32'h3400));
        step();
        chk("hold_noreq", {31'd0, imem_req}, 32'd0);
        chk("hold_pc",    ifid_pc, 32'h3008);
        resp(1'b1, 32'hDEAD_BEEF);
        step(); resp(1'b0, 32'd0);
        chk("hold2_noreq", {31'd0, imem_req}, 32'd0);
        chk("hold2_instr", ifid_instr, word_of(32'h3008));
        stall = 1'b0;
        step();
        chk("skid_pc",    ifid_pc,    32'h3400);
        chk("skid_instr", ifid_instr, word_of(32'h3400));
        chk("skid_pc4",   ifid_pc4,   32'h3404);
        chk("skid_next",  imem_addr,  32'h3404);

        // Redirect coincident with the WAIT accept.
        step(); resp(1'b1, word_of(32'h3404)); redirect = 1'b1; npc_in = 32'h4000;
        step(); resp(1'b0, 32'd0); redirect = 1'b0;
        chk("coinc_pc",   ifid_pc,   32'h3404);
        chk("coinc_addr", imem_addr, 32'h4000);
        step(); resp(1'b1, word_of(32'h4000));
        step(); resp(1'b0, 32'd0);
        chk("no_stale_tgt", imem_addr, 32'h4004);
        chk("coinc_pc2",    ifid_pc,   32'h4000);

        // Wrap-around from 0xFFFF_FFFC, with low npc bits ignored.
        step(); resp(1'b1, word_of(32'h4004)); redirect = 1'b1; npc_in = 32'hFFFF_FFFE;
        step(); resp(1'b0, 32'd0); redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(); resp(1'b1, word_of(32'hFFFF_FFFC));
        step(); resp(1'b0, 32'd0);
        chk("wrap_pc",   ifid_pc,   32'hFFFF_FFFC);
        chk("wrap_pc4",  ifid_pc4,  32'h0000_0000);
        chk("wrap_next", imem_addr, 32'h0000_0000);

        // Reset during WAIT, then a stale response arriving in REQ.
        step();
        chk("pre_rst_wait", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("async_rst_addr",  imem_addr, 32'h3000);
        step();
        rst_n = 1'b1; resp(1'b1, 32'hBAD0_BAD0);
        chk("rerst_req",  {31'd0, imem_req}, 32'd1);
        chk("rerst_addr", imem_addr, 32'h3000);
        step(); resp(1'b0, 32'd0);
        chk("stale_ignored", {31'd0, ifid_valid}, 32'd0);
        chk("stale_wait",    {31'd0, imem_req},   32'd0);
        step(); resp(1'b1, word_of(32'h3000));
        step(); resp(1'b0, 32'd0);
        chk("rerst_pc",    ifid_pc,    32'h3000);
        chk("rerst_instr", ifid_instr, word_of(32'h3000));
        chk("rerst_next",  imem_addr,  32'h3004);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined MIPS core: owns the architectural PC register, issues one word-aligned read at a time to instruction memory, and loads the IF/ID pipeline register (instruction, PC, PC+4). It is the consumer of the next-PC value resolved in ID. The `ifid_pc4` output feeds back to next-PC computation, and `npc_in`/`redirect` come back from it. MIPS branch-delay-slot semantics apply: a redirect never discards the fetch already in flight.

## Interface
- `RESET_PC`, default 32'h0000_3000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `npc_in`  in  32  redirect target from ID; bits [1:0] are ignored and treated as 0.
- `redirect`  in  1  take `npc_in` as the next sequential fetch after the in-flight one.
- `stall`  in  1  hazard stall: the IF/ID register must hold its contents.
- `imem_req`  out  1  single-cycle read request.
- `imem_addr`  out  32  fetch address, valid while `imem_req`.
- `imem_rvalid`  in  1  read data valid; ≥1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `ifid_instr`  out  32  fetched instruction.
- `ifid_pc`  out  32  address of `ifid_instr`.
- `ifid_pc4`  out  32  `ifid_pc` + 4, mod 2^32.

## Operation
- **Registers:** `pc`, state, `tgt`/`tgt_valid` (pending redirect), and IF/ID (`ifid_*`).
- **State REQ:** `imem_req`=1 and `imem_addr`=`pc`. Next state is WAIT, unconditionally (stall does not block the request).
- **State WAIT:** waits for `imem_rvalid`.
  - On `imem_rvalid`, if the IF/ID write is enabled: load IF/ID with {rdata, `pc`, `pc`+4}, set `ifid_valid`=1, update `pc`, go to REQ.
  - Otherwise, capture rdata into the skid register and go to HOLD.
- **State HOLD:** when the IF/ID write becomes enabled, move the skid contents into IF/ID, update `pc`, go to REQ.
- **IF/ID write enable:** `!stall || !ifid_valid`.
- **Bubble:** when `!stall` and no instruction is loaded this cycle, `ifid_valid` is cleared; `ifid_instr`/`ifid_pc`/`ifid_pc4` keep their values.
- **pc update priority:** `redirect` asserted this cycle → {`npc_in`[31:2], 2'b00}; else if `tgt_valid` → `tgt`; else `pc`+4 (wraps at 2^32). Any pc update clears `tgt_valid`.
- **Redirect without pc update:** `tgt` ← {`npc_in`[31:2], 2'b00} and `tgt_valid`=1. A second redirect overwrites the first (last wins).
- **Delay slot:** the fetch outstanding when redirect arrives is the delay slot. It completes and is written to IF/ID normally.
- **Stale data:** `imem_rvalid` is honoured only in WAIT; in REQ or HOLD it is ignored.

## Timing
- **Reset values:** `pc`=`RESET_PC`, state=REQ, `tgt_valid`=0, `ifid_valid`=0, `ifid_instr`=0, `ifid_pc`=0, `ifid_pc4`=0. `imem_req`=1 in the first cycle after `rst_n` deasserts.
- **Latency:** with 1-cycle memory (rvalid the cycle after req), the instruction appears in IF/ID 2 cycles after its request. Throughput is one instruction per 2 cycles.
- **Reset mid-operation:** returns to the reset state immediately. A pending response is dropped via the WAIT-only rule.
- **Redirect coincident with the WAIT accept:** `npc_in` is used directly; `tgt` is not written.
- **Stall in HOLD:** the skid register holds indefinitely; no new request is issued.

## Structure
- **Shared package / `head.v`:** `RESET_PC` default; state encodings `FS_REQ`, `FS_WAIT`, `FS_HOLD` as 2-bit localparam/`define constants alongside the existing NPC op codes.
- **Sub-module `ifid_reg`:** the IF/ID register with write-enable, bubble clear and async active-low reset. The FSM, pc, tgt and skid logic stay in `fetch_unit`.

## Test plan
- **Reset/sequential:** reset, memory returning rdata one cycle after req → `imem_addr` sequence 0x3000, 0x3004, 0x3008. IF/ID shows `ifid_pc4`=0x3004 two cycles after the first req.
- **Redirect in WAIT:** redirect with `npc_in`=0x3401 while fetch 0x3008 is outstanding → IF/ID receives 0x3008 (delay slot), next `imem_addr`=0x3400.
- **Stall/skid:** `stall`=1 with `ifid_valid`=1 when rvalid arrives for 0x300C → state HOLD, no req, IF/ID unchanged. Release stall → IF/ID=0x300C, next req 0x3010.
- **Redirect coincident with accept:** `redirect` in the same cycle as the WAIT accept, `npc_in`=0x4000 → next req 0x4000, `tgt_valid` stays 0.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT; a stale rvalid arriving in REQ → ignored. First req is 0x3000, `ifid_valid`=0.
- **Wrap-around:** redirect to 0xFFFF_FFFC → following sequential req 0x0000_0000; `ifid_pc4`=0x0000_0000 for that instruction.
